// File: rtl/conv_acc_pkg.sv
// Shared definitions for the multi-pass partial-sum accumulator.
//   acc_state_e : controller states
//   fifo_depth  : output FIFO depth for a given bank read latency
//   lane_add    : wrapping lane adder; callers truncate to their lane width
package conv_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

  // Room for every read in flight plus one beat held at the head and one
  // being pushed, so the final pass streams at full rate when s_ready=1.
  localparam int FIFO_SLACK = 2;

  localparam int LANE_MAX_W = 64;

  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + FIFO_SLACK;
  endfunction

  // Two's complement wrap falls out of truncating the unsigned sum.
  function automatic logic [LANE_MAX_W-1:0] lane_add(input logic [LANE_MAX_W-1:0] a,
                                                     input logic [LANE_MAX_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Synchronous output FIFO for final-pass results.
//   clk, rst      : clock, asynchronous active-high reset (flushes contents)
//   push, din     : write side (push ignored when full)
//   pop, dout     : read side, dout is the current head (ignored when empty)
//   empty         : no entries
//   count         : current occupancy, used by the upstream credit check
module acc_out_fifo
  import conv_acc_pkg::*;
#(
  parameter int W     = 132,
  parameter int DEPTH = 3,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, full;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Contents are cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/conv_psum_pass_acc.sv
// Multi-pass convolution partial-sum accumulator.
// Each pass reads a product word (bank 1) and a bias/partial-sum word
// (bank 2), adds them lane-wise with wrap, and either writes the result back
// to bank 2 (intermediate passes) or streams it through a small output FIFO
// with backpressure (final pass).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid / cfg_ready    configuration handshake (ready only when idle)
//   cfg_base1, cfg_base2     bank 1 / bank 2 base addresses
//   cfg_len, cfg_npass       words per pass, pass count (0 treated as 1)
//   m_rd_en, m_addr1/2       bank read strobe and addresses
//   m_data1/2                bank read data, RD_LAT cycles after the strobe
//   m_sum, m_wr_addr, m_valid  bank 2 write-back of intermediate sums
//   s_sum, s_valid, s_ready  final result stream
//   busy, done               activity flag, one-cycle completion pulse
//
// Build option: ACC_RELU_EN clamps negative final-pass lanes to zero;
// write-back partial sums are never clamped.
//
// state | meaning
// IDLE  | waiting for a configuration
// RUN   | issuing one read per cycle (final pass limited by FIFO credit)
// DRAIN | waiting for in-flight reads, write-back and (final) FIFO to empty
// DONE  | one-cycle completion pulse
module conv_psum_pass_acc
  import conv_acc_pkg::*;
#(
  parameter int AW     = 11,
  parameter int DW     = 22,
  parameter int DN     = 6,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [AW-1:0]    cfg_base1,
  input  logic [AW-1:0]    cfg_base2,
  input  logic [7:0]       cfg_len,
  input  logic [3:0]       cfg_npass,
  output logic             m_rd_en,
  output logic [AW-1:0]    m_addr1,
  output logic [AW-1:0]    m_addr2,
  input  logic [DW*DN-1:0] m_data1,
  input  logic [DW*DN-1:0] m_data2,
  output logic [DW*DN-1:0] m_sum,
  output logic [AW-1:0]    m_wr_addr,
  output logic             m_valid,
  output logic [DW*DN-1:0] s_sum,
  output logic             s_valid,
  input  logic             s_ready,
  output logic             busy,
  output logic             done
);

  localparam int LW    = DW * DN;
  localparam int DEPTH = fifo_depth(RD_LAT);
  localparam int CW    = $clog2(DEPTH + 1);

  acc_state_e        state_q, state_d;
  logic [AW-1:0]     addr1_q, addr1_d;
  logic [AW-1:0]     addr2_q, addr2_d;
  logic [AW-1:0]     base2_q, base2_d;
  logic [AW-1:0]     wb_ptr_q, wb_ptr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        remain_q, remain_d;
  logic [3:0]        last_q, last_d;
  logic [3:0]        p_q, p_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [LW-1:0]     m_sum_q, m_sum_d;
  logic [AW-1:0]     m_wr_addr_q, m_wr_addr_d;
  logic              m_valid_q, m_valid_d;

  logic [LW-1:0]     raw_sum, fin_sum;
  logic              issue, arrive, final_pass, credit_ok, drained;
  logic              fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [LW-1:0]     fifo_dout;
  int                occ;

  always_comb begin
    raw_sum = '0;
    for (int k = 0; k < DN; k++) begin
      raw_sum[k*DW +: DW] = DW'(lane_add(LANE_MAX_W'(m_data1[k*DW +: DW]),
                                         LANE_MAX_W'(m_data2[k*DW +: DW])));
    end
    fin_sum = raw_sum;
`ifdef ACC_RELU_EN
    for (int k = 0; k < DN; k++) begin
      if (raw_sum[k*DW + DW - 1]) fin_sum[k*DW +: DW] = '0;
    end
`endif
  end

  // Credit counts reads still in the latency pipe plus FIFO entries, so an
  // issued final-pass read always has a FIFO slot when its data returns.
  always_comb begin
    occ = int'(fifo_count);
    for (int k = 0; k < RD_LAT; k++) occ = occ + int'(vld_q[k]);
    credit_ok = (occ < DEPTH);
  end

  assign final_pass = (p_q == last_q);
  assign arrive     = vld_q[RD_LAT-1];
  assign fifo_pop   = s_valid && s_ready;
  // On the final pass a beat leaving this cycle counts as already drained,
  // so done lands the cycle after the last accept.
  assign drained    = (vld_q == '0) && !m_valid_q &&
                      (!final_pass || (fifo_count == '0) ||
                       ((fifo_count == CW'(1)) && fifo_pop));

  always_comb begin
    state_d     = state_q;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    base2_d     = base2_q;
    wb_ptr_d    = wb_ptr_q;
    len_d       = len_q;
    remain_d    = remain_q;
    last_d      = last_q;
    p_d         = p_q;
    m_sum_d     = m_sum_q;
    m_wr_addr_d = m_wr_addr_q;
    m_valid_d   = 1'b0;
    issue       = 1'b0;
    fifo_push   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          addr1_d  = cfg_base1;
          addr2_d  = cfg_base2;
          base2_d  = cfg_base2;
          wb_ptr_d = cfg_base2;
          len_d    = cfg_len;
          remain_d = cfg_len;
          last_d   = (cfg_npass == 4'd0) ? 4'd0 : cfg_npass - 4'd1;
          p_d      = '0;
          state_d  = (cfg_len != 8'd0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (!final_pass || credit_ok) begin
          issue    = 1'b1;
          // Passes are contiguous in bank 1, so addr1 just keeps counting.
          addr1_d  = addr1_q + 1'b1;
          addr2_d  = addr2_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (remain_q == 8'd1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          if (final_pass) begin
            state_d = DONE;
          end else begin
            p_d      = p_q + 1'b1;
            addr2_d  = base2_q;
            wb_ptr_d = base2_q;
            remain_d = len_q;
            state_d  = (len_q != 8'd0) ? RUN : DRAIN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // p cannot advance while reads are in flight, so p_q identifies the
    // pass each returning word belongs to.
    if (arrive) begin
      if (final_pass) begin
        fifo_push = 1'b1;
      end else begin
        m_sum_d     = raw_sum;
        m_wr_addr_d = wb_ptr_q;
        m_valid_d   = 1'b1;
        wb_ptr_d    = wb_ptr_q + 1'b1;
      end
    end
  end

  assign vld_d = (vld_q << 1) | RD_LAT'(issue);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr1_q     <= '0;
      addr2_q     <= '0;
      base2_q     <= '0;
      wb_ptr_q    <= '0;
      len_q       <= '0;
      remain_q    <= '0;
      last_q      <= '0;
      p_q         <= '0;
      vld_q       <= '0;
      m_sum_q     <= '0;
      m_wr_addr_q <= '0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      base2_q     <= base2_d;
      wb_ptr_q    <= wb_ptr_d;
      len_q       <= len_d;
      remain_q    <= remain_d;
      last_q      <= last_d;
      p_q         <= p_d;
      vld_q       <= vld_d;
      m_sum_q     <= m_sum_d;
      m_wr_addr_q <= m_wr_addr_d;
      m_valid_q   <= m_valid_d;
    end
  end

  acc_out_fifo #(
    .W     (LW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_out_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fin_sum),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign m_rd_en   = issue;
  assign m_addr1   = addr1_q;
  assign m_addr2   = addr2_q;
  assign m_sum     = m_sum_q;
  assign m_wr_addr = m_wr_addr_q;
  assign m_valid   = m_valid_q;
  assign s_valid   = !fifo_empty;
  assign s_sum     = fifo_dout;

endmodule

// File: tb/tb_conv_psum_pass_acc.sv
module tb_conv_psum_pass_acc;
  localparam int AW = 11;
  localparam int DW = 22;
  localparam int DN = 6;
  localparam int RD_LAT = 2;
  localparam int SW = DW * DN;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid, cfg_ready;
  logic [AW-1:0] cfg_base1, cfg_base2;
  logic [7:0]    cfg_len;
  logic [3:0]    cfg_npass;
  logic          m_rd_en;
  logic [AW-1:0] m_addr1, m_addr2, m_wr_addr;
  logic [SW-1:0] m_data1, m_data2, m_sum, s_sum;
  logic          m_valid, s_valid, s_ready, busy, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_psum_pass_acc #(.AW(AW), .DW(DW), .DN(DN), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base1(cfg_base1), .cfg_base2(cfg_base2),
    .cfg_len(cfg_len), .cfg_npass(cfg_npass),
    .m_rd_en(m_rd_en), .m_addr1(m_addr1), .m_addr2(m_addr2),
    .m_data1(m_data1), .m_data2(m_data2),
    .m_sum(m_sum), .m_wr_addr(m_wr_addr), .m_valid(m_valid),
    .s_sum(s_sum), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done)
  );

  function automatic logic [SW-1:0] rep(input logic [DW-1:0] v);
    return {DN{v}};
  endfunction

  // Bank 1 product contents
  function automatic logic [SW-1:0] bank1_fn(input logic [AW-1:0] a);
    if (a >= 11'h010 && a <= 11'h013) return rep(22'd5);
    if (a >= 11'h040 && a <= 11'h042) return rep(22'd2);
    if (a >= 11'h043 && a <= 11'h045) return rep(22'd3);
    if (a >= 11'h046 && a <= 11'h048) return rep(22'd4);
    if (a >= 11'h200 && a <= 11'h207) return rep(22'(a - 11'h200) + 22'd1);
    if (a == 11'h410) return rep(22'd1);
    if (a >= 11'h500 && a <= 11'h50F) return rep(22'd7);
    return '0;
  endfunction

  // Bank 2 preloaded bias contents
  function automatic logic [SW-1:0] bias_fn(input logic [AW-1:0] a);
    if (a >= 11'h020 && a <= 11'h023) return rep(22'd10);
    if (a >= 11'h100 && a <= 11'h102) return rep(22'd1);
    if (a >= 11'h300 && a <= 11'h307) return rep(22'd100);
    if (a == 11'h400) return rep(22'h1FFFFF);
    if (a >= 11'h700 && a <= 11'h701) return rep(22'd20);
    return '0;
  endfunction

  // Bank model with RD_LAT=2 read pipeline; write-backs overlay the bias
  logic [SW-1:0] rp1 [2];
  logic [SW-1:0] rp2 [2];
  logic [SW-1:0] wb_mem [2048];
  bit            wb_vld [2048];

  always @(posedge clk) begin
    rp1[0] <= m_rd_en ? bank1_fn(m_addr1) : '0;
    rp2[0] <= m_rd_en ? (wb_vld[m_addr2] ? wb_mem[m_addr2] : bias_fn(m_addr2)) : '0;
    rp1[1] <= rp1[0];
    rp2[1] <= rp2[0];
    if (m_valid) begin
      wb_mem[m_wr_addr] <= m_sum;
      wb_vld[m_wr_addr] <= 1'b1;
    end
  end
  assign m_data1 = rp1[1];
  assign m_data2 = rp2[1];

  // Monitors
  int            cyc = 0, rd_cnt = 0, beat_cnt = 0, wb_cnt = 0, done_cnt = 0;
  int            stall_err = 0, outst = 0, max_out = 0;
  logic [AW-1:0] rd_a1 [256];
  int            rd_cyc [256];
  logic [SW-1:0] s_log [64];
  logic [SW-1:0] wb_log [64];
  logic [AW-1:0] wba_log [64];
  logic          prev_stall = 1'b0;
  logic [SW-1:0] prev_sum = '0;
  bit            track = 1'b0;

  always @(posedge clk) begin
    int nxt;
    cyc <= cyc + 1;
    if (m_rd_en) begin
      rd_a1[rd_cnt % 256]  <= m_addr1;
      rd_cyc[rd_cnt % 256] <= cyc;
      rd_cnt <= rd_cnt + 1;
    end
    if (s_valid && s_ready) begin
      s_log[beat_cnt % 64] <= s_sum;
      beat_cnt <= beat_cnt + 1;
    end
    if (m_valid) begin
      wb_log[wb_cnt % 64]  <= m_sum;
      wba_log[wb_cnt % 64] <= m_wr_addr;
      wb_cnt <= wb_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    prev_stall <= s_valid && !s_ready;
    prev_sum   <= s_sum;
    if (prev_stall && s_valid && (s_sum !== prev_sum)) stall_err <= stall_err + 1;
    nxt = outst + int'(m_rd_en) - int'(s_valid && s_ready);
    if (!track) begin
      outst   <= 0;
      max_out <= 0;
    end else begin
      outst <= nxt;
      if (nxt > max_out) max_out <= nxt;
    end
  end

  task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_cfg(input logic [AW-1:0] b1, input logic [AW-1:0] b2,
                           input logic [7:0] len, input logic [3:0] np);
    cfg_base1 = b1;
    cfg_base2 = b2;
    cfg_len   = len;
    cfg_npass = np;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc, input int mode);
    int  d0;
    bit  seen;
    d0   = done_cnt;
    seen = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(negedge clk);
      if (mode == 1) s_ready = (k % 3 == 0);
      if (done_cnt != d0) seen = 1'b1;
    end
    s_ready = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, SW'(done_cnt - d0), SW'(1));
  endtask

  int b0, w0, r0, st0;
  logic [SW-1:0] relu_exp;

  initial begin
    cfg_valid = 1'b0;
    cfg_base1 = '0;
    cfg_base2 = '0;
    cfg_len   = '0;
    cfg_npass = '0;
    s_ready   = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_cfg_ready", SW'(cfg_ready), SW'(1));
    check("rst_busy",      SW'(busy),      SW'(0));
    check("rst_done",      SW'(done),      SW'(0));
    check("rst_rd_en",     SW'(m_rd_en),   SW'(0));
    check("rst_m_valid",   SW'(m_valid),   SW'(0));
    check("rst_s_valid",   SW'(s_valid),   SW'(0));
    check("rst_addr1",     SW'(m_addr1),   SW'(0));
    check("rst_addr2",     SW'(m_addr2),   SW'(0));
    check("rst_wr_addr",   SW'(m_wr_addr), SW'(0));
    check("rst_m_sum",     m_sum,          SW'(0));
    check("rst_s_sum",     s_sum,          SW'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1: single pass, bias 10 + product 5
    b0 = beat_cnt; w0 = wb_cnt; r0 = rd_cnt;
    start_cfg(11'h010, 11'h020, 8'd4, 4'd1);
    check("t1_first_rd_en", SW'(m_rd_en),   SW'(1));
    check("t1_first_addr1", SW'(m_addr1),   SW'(11'h010));
    check("t1_first_addr2", SW'(m_addr2),   SW'(11'h020));
    check("t1_busy",        SW'(busy),      SW'(1));
    check("t1_cfg_ready",   SW'(cfg_ready), SW'(0));
    wait_done("t1", 200, 0);
    check("t1_reads", SW'(rd_cnt - r0),   SW'(4));
    check("t1_beats", SW'(beat_cnt - b0), SW'(4));
    check("t1_no_wb", SW'(wb_cnt - w0),   SW'(0));
    for (int i = 0; i < 4; i++) check("t1_beat", s_log[(b0 + i) % 64], rep(22'd15));

    // 2: three passes, write-back then final stream; cfg during busy ignored
    b0 = beat_cnt; w0 = wb_cnt; r0 = rd_cnt;
    start_cfg(11'h040, 11'h100, 8'd3, 4'd3);
    cfg_valid = 1'b1;
    cfg_len   = 8'd5;
    cfg_base1 = 11'h7F0;
    for (int i = 0; i < 3; i++) begin
      check("t2_busy_cfg_ready", SW'(cfg_ready), SW'(0));
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    wait_done("t2", 300, 0);
    check("t2_reads",      SW'(rd_cnt - r0), SW'(9));
    check("t2_addr1_lo",   SW'(rd_a1[r0 % 256]), SW'(11'h040));
    check("t2_addr1_hi",   SW'(rd_a1[(r0 + 8) % 256]), SW'(11'h048));
    check("t2_turnaround", SW'(rd_cyc[(r0 + 3) % 256] - rd_cyc[(r0 + 2) % 256]), SW'(RD_LAT + 3));
    check("t2_wb_count",   SW'(wb_cnt - w0), SW'(6));
    for (int i = 0; i < 6; i++) begin
      check("t2_wb_addr", SW'(wba_log[(w0 + i) % 64]), SW'(11'h100 + i % 3));
      check("t2_wb_data", wb_log[(w0 + i) % 64], (i < 3) ? rep(22'd3) : rep(22'd6));
    end
    check("t2_beats", SW'(beat_cnt - b0), SW'(3));
    for (int i = 0; i < 3; i++) check("t2_beat", s_log[(b0 + i) % 64], rep(22'd10));

    // 3: backpressured final pass, s_ready 1 of 3 cycles
    b0 = beat_cnt; st0 = stall_err;
    track = 1'b1;
    start_cfg(11'h200, 11'h300, 8'd8, 4'd1);
    wait_done("t3", 300, 1);
    check("t3_beats", SW'(beat_cnt - b0), SW'(8));
    for (int i = 0; i < 8; i++) check("t3_beat", s_log[(b0 + i) % 64], rep(22'(101 + i)));
    check("t3_credit_bound", SW'(max_out <= RD_LAT + 2), SW'(1));
    check("t3_stall_hold",   SW'(stall_err - st0), SW'(0));
    track = 1'b0;

    // 4: lane overflow wraps; write-back never clamped
    b0 = beat_cnt; w0 = wb_cnt;
`ifdef ACC_RELU_EN
    relu_exp = rep(22'd0);
`else
    relu_exp = rep(22'h200000);
`endif
    start_cfg(11'h410, 11'h400, 8'd1, 4'd2);
    wait_done("t4", 200, 0);
    check("t4_wb_count", SW'(wb_cnt - w0), SW'(1));
    check("t4_wb_data",  wb_log[w0 % 64], rep(22'h200000));
    check("t4_wb_addr",  SW'(wba_log[w0 % 64]), SW'(11'h400));
    check("t4_beats",    SW'(beat_cnt - b0), SW'(1));
    check("t4_beat",     s_log[b0 % 64], relu_exp);

    // 5: zero-length passes
    b0 = beat_cnt; w0 = wb_cnt; r0 = rd_cnt;
    start_cfg(11'h000, 11'h000, 8'd0, 4'd2);
    wait_done("t5", 50, 0);
    check("t5_reads", SW'(rd_cnt - r0),   SW'(0));
    check("t5_beats", SW'(beat_cnt - b0), SW'(0));
    check("t5_wb",    SW'(wb_cnt - w0),   SW'(0));

    // 6: reset during second pass, then a fresh run
    start_cfg(11'h500, 11'h600, 8'd8, 4'd2);
    repeat (14) @(negedge clk);
    check("t6_busy_before", SW'(busy), SW'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t6_cfg_ready", SW'(cfg_ready), SW'(1));
    check("t6_busy",      SW'(busy),      SW'(0));
    check("t6_rd_en",     SW'(m_rd_en),   SW'(0));
    check("t6_s_valid",   SW'(s_valid),   SW'(0));
    check("t6_m_valid",   SW'(m_valid),   SW'(0));
    check("t6_addr1",     SW'(m_addr1),   SW'(0));
    check("t6_m_sum",     m_sum,          SW'(0));
    check("t6_s_sum",     s_sum,          SW'(0));
    rst = 1'b0;
    @(negedge clk);
    b0 = beat_cnt;
    start_cfg(11'h500, 11'h700, 8'd2, 4'd1);
    wait_done("t6", 200, 0);
    check("t6_beats", SW'(beat_cnt - b0), SW'(2));
    for (int i = 0; i < 2; i++) check("t6_beat", s_log[(b0 + i) % 64], rep(22'd27));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
